demux14_tdm: RTL and testbench
==============================

DEMUX14_TDM -- requirements
Module: demux14_tdm

Interface
REQ-001 The block SHALL have parameter W, default 1, the data width of the serial input and of each output lane.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port din, input, W bits: the time-multiplexed slot data, slots ordered d0, d1, d2, d3.
REQ-005 The block SHALL have port valid, input, 1 bit: din carries one slot this cycle.
REQ-006 The block SHALL have port frame, input, 1 bit: qualified by valid, marks the current slot as slot 0.
REQ-007 The block SHALL have ports q0, q1, q2, q3, output, W bits each: the demultiplexed lanes, registered.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse when q0..q3 update.
REQ-009 The block SHALL have ports s0, s1, output, 1 bit each: the next expected slot index, s1 the MSB.
REQ-010 The block SHALL have port locked, output, 1 bit: high in state SYNC.
REQ-011 The block SHALL have port sync_err, output, 1 bit: single-cycle pulse on a framing violation.

Function
REQ-012 The block SHALL implement two states: HUNT (no alignment) and SYNC (aligned).
REQ-013 In HUNT, the block SHALL ignore din until a cycle with valid=1 and frame=1, then capture din as slot 0, set the slot index to 1 and enter SYNC.
REQ-014 In SYNC, each cycle with valid=1 SHALL capture din into the shadow register of the current slot and increment the slot index modulo 4.
REQ-015 Cycles with valid=0 SHALL change no state; gaps of any length between slots SHALL be tolerated.
REQ-016 On capture of slot 3, the block SHALL, on the same clock edge, load q0..q2 from the shadows, load q3 from din and assert done for exactly one cycle.
REQ-017 The latency from the valid slot-3 input cycle to the q update and done pulse SHALL be one clock edge.
REQ-018 Between updates, q0..q3 SHALL hold their values; a partial frame SHALL never appear on q0..q3.
REQ-019 In SYNC, frame=1 with valid=1 at slot index 0 SHALL be accepted as normal; frame absence at slot 0 SHALL NOT be an error (flywheel).
REQ-020 In SYNC, frame=1 with valid=1 at slot index 1..3 SHALL pulse sync_err, discard the partial frame, capture din as the new slot 0, set the index to 1 and remain in SYNC.
REQ-021 The slot index SHALL wrap from 3 to 0; s1,s0 SHALL present the next expected slot index every cycle.
REQ-022 Asserting rst mid-frame SHALL abandon the partial frame without a done pulse.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL enter HUNT, clear the slot index, clear all shadow registers, and clear q0..q3, done, s0, s1, locked and sync_err to 0.
REQ-024 rst SHALL take priority over valid and frame in the same cycle.

Configuration
REQ-025 With macro DEMUX14_TDM_ERRCNT_EN defined, the block SHALL add output err_cnt, 8 bits, which is reset to 0, increments on each sync_err pulse and saturates at 255.
REQ-026 Without DEMUX14_TDM_ERRCNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 The bench SHALL cover reset then frame-aligned stream A,B,C,D (W=4: 1,2,3,4) with valid=1 -> done one cycle after D; q0..q3=1,2,3,4; locked=1 from the cycle after A.
REQ-028 The bench SHALL cover slots 5,6,7,8 with valid=0 gaps of 3 cycles between slots -> q0..q3=5,6,7,8; a single done pulse; q held during the gaps.
REQ-029 The bench SHALL cover frame=1 at slot 2 mid-frame -> sync_err pulse; the following frame 9,10,11,12 (starting with the misframed slot) -> q0..q3=9,10,11,12; old partial data discarded.
REQ-030 The bench SHALL cover valid data with frame=0 while in HUNT -> no capture; q stays 0; locked=0; done never asserted.
REQ-031 The bench SHALL cover rst asserted after slot 1 of a frame -> all outputs 0 and state HUNT next cycle; no done pulse.
REQ-032 The bench SHALL cover, with DEMUX14_TDM_ERRCNT_EN defined, 300 forced misframes -> err_cnt=255 and held at 255.

Source files
------------

// File: rtl/demux14_tdm.sv
// demux14_tdm: 1-to-4 TDM slot demultiplexer with frame hunt/sync tracking.
// Optional DEMUX14_TDM_ERRCNT_EN adds a saturating 8-bit misframe counter.
module demux14_tdm #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         valid,
    input  logic         frame,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1,
    output logic [W-1:0] q2,
    output logic [W-1:0] q3,
    output logic         done,
    output logic         s0,
    output logic         s1,
    output logic         locked,
    output logic         sync_err
`ifdef DEMUX14_TDM_ERRCNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    typedef enum logic {
        HUNT,
        SYNC
    } state_t;

    state_t       state;
    state_t       state_d;
    logic [1:0]   idx;
    logic [1:0]   idx_d;
    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic [W-1:0] sh2;

    logic         cap;
    logic         restart;
    logic         misframe;
    logic         complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            idx   <= 2'd0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        cap      = 1'b0;
        restart  = 1'b0;
        misframe = 1'b0;
        complete = 1'b0;
        unique case (state)
            HUNT: begin
                if (valid && frame) begin
                    state_d = SYNC;
                    idx_d   = 2'd1;
                    restart = 1'b1;
                end
            end
            SYNC: begin
                if (valid) begin
                    // frame outside slot 0 realigns on the current slot
                    if (frame && idx != 2'd0) begin
                        misframe = 1'b1;
                        restart  = 1'b1;
                        idx_d    = 2'd1;
                    end else begin
                        cap      = 1'b1;
                        idx_d    = idx + 2'd1;
                        complete = (idx == 2'd3);
                    end
                end
            end
        endcase
    end

    always_comb begin
        locked = (state == SYNC);
        s1     = idx[1];
        s0     = idx[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh0      <= '0;
            sh1      <= '0;
            sh2      <= '0;
            q0       <= '0;
            q1       <= '0;
            q2       <= '0;
            q3       <= '0;
            done     <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            done     <= complete;
            sync_err <= misframe;
            if (restart) begin
                sh0 <= din;
                sh1 <= '0;
                sh2 <= '0;
            end else if (cap) begin
                unique case (idx)
                    2'd0: sh0 <= din;
                    2'd1: sh1 <= din;
                    2'd2: sh2 <= din;
                    2'd3: ;
                endcase
            end
            if (complete) begin
                q0 <= sh0;
                q1 <= sh1;
                q2 <= sh2;
                q3 <= din;
            end
        end
    end

`ifdef DEMUX14_TDM_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (misframe && err_cnt != 8'hff) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux14_tdm.sv
// tb_demux14_tdm: directed + random checks of demux14_tdm against a
// queue-based frame model.
module tb_demux14_tdm;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din;
    logic         valid;
    logic         frame;
    logic [W-1:0] q0, q1, q2, q3;
    logic         done, s0, s1, locked, sync_err;
`ifdef DEMUX14_TDM_ERRCNT_EN
    logic [7:0]   err_cnt;
`endif

    demux14_tdm #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .valid    (valid),
        .frame    (frame),
        .q0       (q0),
        .q1       (q1),
        .q2       (q2),
        .q3       (q3),
        .done     (done),
        .s0       (s0),
        .s1       (s1),
        .locked   (locked),
        .sync_err (sync_err)
`ifdef DEMUX14_TDM_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: slots collected so far in the current frame
    bit           m_sync = 0;
    logic [W-1:0] m_part[$];
    logic [W-1:0] m_q[4] = '{default: '0};
    bit           m_done = 0;
    bit           m_err  = 0;
    int           m_errs = 0;
    int           done_seen = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(bit r, bit v, bit f, logic [W-1:0] d);
        m_done = 0;
        m_err  = 0;
        if (r) begin
            m_sync = 0;
            m_part.delete();
            m_q    = '{default: '0};
            m_errs = 0;
            return;
        end
        if (!v) return;
        if (!m_sync) begin
            if (f) begin
                m_sync = 1;
                m_part.push_back(d);
            end
            return;
        end
        if (f && m_part.size() != 0) begin
            m_err = 1;
            if (m_errs < 255) m_errs++;
            m_part.delete();
        end
        m_part.push_back(d);
        if (m_part.size() == 4) begin
            for (int i = 0; i < 4; i++) m_q[i] = m_part[i];
            m_part.delete();
            m_done = 1;
        end
    endtask

    task automatic step(bit r, bit v, bit f, logic [W-1:0] d);
        rst   = r;
        valid = v;
        frame = f;
        din   = d;
        @(posedge clk);
        model(r, v, f, d);
        #1;
        chk("q0", q0, m_q[0]);
        chk("q1", q1, m_q[1]);
        chk("q2", q2, m_q[2]);
        chk("q3", q3, m_q[3]);
        chk("done", done, m_done);
        chk("sync_err", sync_err, m_err);
        chk("locked", locked, m_sync);
        chk("slot", {s1, s0}, m_part.size());
`ifdef DEMUX14_TDM_ERRCNT_EN
        chk("err_cnt", err_cnt, m_errs);
`endif
        if (done === 1'b1) done_seen++;
        @(negedge clk);
    endtask

    int d0;

    initial begin
        rst = 1; valid = 0; frame = 0; din = '0;

        // reset state
        step(1, 0, 0, 4'h0);
        chk("rst_locked", locked, 0);
        chk("rst_q0", q0, 0);

        // data without frame in HUNT is ignored
        d0 = done_seen;
        for (int i = 0; i < 6; i++) step(0, 1, 0, 4'(i + 3));
        chk("hunt_locked", locked, 0);
        chk("hunt_q1", q1, 0);
        chk("hunt_done", done_seen - d0, 0);

        // aligned frame 1,2,3,4
        step(0, 1, 1, 4'd1);
        chk("f1_locked", locked, 1);
        step(0, 1, 0, 4'd2);
        step(0, 1, 0, 4'd3);
        chk("f1_nodone", done, 0);
        step(0, 1, 0, 4'd4);
        chk("f1_done", done, 1);
        chk("f1_q0", q0, 1);
        chk("f1_q3", q3, 4);

        // slots 5..8 with 3-cycle gaps
        d0 = done_seen;
        for (int s = 0; s < 4; s++) begin
            step(0, 1, 0, 4'(5 + s));
            if (s < 3)
                for (int g = 0; g < 3; g++)
                    step(0, 0, 1'($urandom), 4'($urandom));
        end
        chk("gap_q0", q0, 5);
        chk("gap_q3", q3, 8);
        chk("gap_done_cnt", done_seen - d0, 1);
        step(0, 0, 0, 4'h0);
        chk("gap_hold_q2", q2, 7);

        // misframe at slot 2, then realigned frame 9..12
        step(0, 1, 1, 4'd13);
        step(0, 1, 0, 4'd14);
        step(0, 1, 1, 4'd9);
        chk("mis_err", sync_err, 1);
        chk("mis_locked", locked, 1);
        step(0, 1, 0, 4'd10);
        chk("mis_err_pulse", sync_err, 0);
        step(0, 1, 0, 4'd11);
        step(0, 1, 0, 4'd12);
        chk("mis_q0", q0, 9);
        chk("mis_q1", q1, 10);
        chk("mis_q3", q3, 12);

        // reset mid-frame
        d0 = done_seen;
        step(0, 1, 1, 4'd1);
        step(0, 1, 0, 4'd2);
        step(1, 1, 0, 4'd3);
        chk("rmid_q0", q0, 0);
        chk("rmid_locked", locked, 0);
        step(0, 1, 0, 4'd4);
        chk("rmid_done", done_seen - d0, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 4'($urandom));

        // many misframes: counter saturates
        step(1, 0, 0, 4'h0);
        for (int i = 0; i < 301; i++) step(0, 1, 1, 4'($urandom));
`ifdef DEMUX14_TDM_ERRCNT_EN
        chk("errcnt_sat", err_cnt, 255);
`endif
        for (int i = 0; i < 5; i++) step(0, 1, 1, 4'($urandom));
`ifdef DEMUX14_TDM_ERRCNT_EN
        chk("errcnt_hold", err_cnt, 255);
`endif
        chk("err_model_sat", m_errs, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
